instruction_memory_sync: RTL
============================

INSTRUCTION_MEMORY_SYNC -- requirements
Module: instruction_memory_sync

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-address bits; DEPTH = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction width in bits.
REQ-003 SHALL have parameter NOP_INST, default 32'h00000000, meaning the word driven when no valid instruction is available.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port load_en  input  1  write strobe for the program-load port.
REQ-007 SHALL have port load_addr  input  ADDR_W  word index to write.
REQ-008 SHALL have port load_data  input  DATA_W  instruction word to write.
REQ-009 SHALL have port load_done  input  1  single-cycle pulse that ends program loading.
REQ-010 SHALL have port fetch_req  input  1  fetch request from the IF stage.
REQ-011 SHALL have port Address  input  32  byte address; Address[ADDR_W+1:2] selects the word.
REQ-012 SHALL have port stall  input  1  holds the current fetch output.
REQ-013 SHALL have port Instruction  output  DATA_W  registered fetched word.
REQ-014 SHALL have port inst_valid  output  1  Instruction holds a valid fetch result.
REQ-015 SHALL have port addr_err  output  1  the last accepted fetch was misaligned or out of range.
REQ-016 SHALL have port running  output  1  high in state RUN.
REQ-017 SHALL have port load_cnt  output  ADDR_W+1  count of accepted load writes, saturating at DEPTH.

Function
REQ-018 SHALL implement a two-state FSM: LOAD (entered on reset) and RUN; LOAD->RUN on load_done=1; RUN->LOAD only on reset.
REQ-019 In LOAD, load_en=1 SHALL write load_data to mem[load_addr] at the clock edge and increment load_cnt (saturate at DEPTH).
REQ-020 In RUN, load_en SHALL be ignored: no write and no load_cnt change.
REQ-021 If load_en and load_done are high in the same cycle in LOAD, the write SHALL complete and the FSM SHALL enter RUN.
REQ-022 In LOAD, fetch_req SHALL be ignored and inst_valid SHALL stay 0.
REQ-023 In RUN with stall=0 and fetch_req=1, a fetch SHALL be accepted: after one clock, Instruction=mem[word] and inst_valid=1 (latency exactly 1 cycle).
REQ-024 In RUN with stall=0 and fetch_req=0, after one clock Instruction=NOP_INST and inst_valid=0.
REQ-025 With stall=1, Instruction, inst_valid and addr_err SHALL hold their values regardless of fetch_req and Address.
REQ-026 An accepted fetch with Address[1:0]!=0 or Address[31:ADDR_W+2]!=0 SHALL return NOP_INST with inst_valid=1 and addr_err=1; otherwise addr_err=0.
REQ-027 Memory contents SHALL have no reset; words never written SHALL read as NOP_INST (array initialised to NOP_INST at time zero).
REQ-028 Address wrap-around SHALL NOT occur; out-of-range addresses are handled only by REQ-026.

Reset
REQ-029 On reset assertion, asynchronously: FSM=LOAD, Instruction=NOP_INST, inst_valid=0, addr_err=0, running=0, load_cnt=0.
REQ-030 Reset during RUN or during a load SHALL preserve memory contents; any write on the edge coincident with reset SHALL be dropped.
REQ-031 After reset deassertion, the first write SHALL be accepted on the next rising edge.

Verification
REQ-032 Load mem[0]=32'h241a0001 and mem[1]=32'h8c080000, pulse load_done, fetch Address=0 then 4 -> Instruction 32'h241a0001 then 32'h8c080000, one cycle after each request, inst_valid=1.
REQ-033 In RUN, fetch Address=4, assert stall for 3 cycles while Address changes to 8 -> Instruction held at 32'h8c080000 with inst_valid=1; after stall drops, Address=8 result appears one cycle later.
REQ-034 Fetch Address=32'h00000002 and Address=32'h00000400 (ADDR_W=8) -> NOP_INST, inst_valid=1, addr_err=1.
REQ-035 Issue 300 load writes with ADDR_W=8 -> load_cnt saturates at 256; load_en after load_done -> memory unchanged on read-back.
REQ-036 Assert reset mid-RUN, then reload nothing and pulse load_done -> fetch Address=0 returns the previously loaded 32'h241a0001; running=0 and inst_valid=0 immediately on reset.

Source files
------------

// File: rtl/instruction_memory_sync.sv
// Instruction memory with a program-load port and a registered, stallable fetch port.
// A LOAD/RUN mode FSM gates writes (LOAD only) and fetches (RUN only).
module instruction_memory_sync #(
    parameter int unsigned        ADDR_W   = 8,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_INST = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    input  logic              fetch_req,
    input  logic [31:0]       Address,
    input  logic              stall,
    output logic [DATA_W-1:0] Instruction,
    output logic              inst_valid,
    output logic              addr_err,
    output logic              running,
    output logic [ADDR_W:0]   load_cnt
);

    localparam int unsigned    Depth  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CntMax = (ADDR_W + 1)'(Depth);
    localparam logic [ADDR_W:0] CntOne = (ADDR_W + 1)'(1);

    typedef enum logic [0:0] {StLoad, StRun} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              mem_we;
    logic              addr_bad;
    logic [ADDR_W-1:0] fetch_word;

    // No reset on the array: contents survive reset, unwritten words read as NOP_INST.
    logic [DATA_W-1:0] mem [Depth] = '{default: NOP_INST};

    assign fetch_word = Address[ADDR_W+1:2];
    assign addr_bad   = (Address[1:0] != 2'b00) || (Address[31:ADDR_W+2] != '0);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StLoad: begin
                // A write on the edge that coincides with reset is dropped.
                if (load_en && !reset) begin
                    mem_we = 1'b1;
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                if (load_done) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!stall) begin
                    if (fetch_req) begin
                        valid_d = 1'b1;
                        err_d   = addr_bad;
                        instr_d = addr_bad ? NOP_INST : mem[fetch_word];
                    end else begin
                        valid_d = 1'b0;
                        err_d   = 1'b0;
                        instr_d = NOP_INST;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StLoad;
            instr_q <= NOP_INST;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

    assign Instruction = instr_q;
    assign inst_valid  = valid_q;
    assign addr_err    = err_q;
    assign running     = (state_q == StRun);
    assign load_cnt    = cnt_q;

endmodule
